uart_tx_buffered: RTL

- Serial-line transmitter at the far end of the multichannel packetizer's send interface.
- Accepts PACKET_SIZE-bit words as single-cycle send_flag/send_data pulses and buffers them in a FIFO.
- Drives sendable back to the packetizer as flow control.
- Serialises each word as an asynchronous UART frame on tx: start bit, data LSB first, stop bit(s).

---
 rtl/uart_tx_buffered_if.sv | 11 +
 rtl/uart_tx_buffered.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake between the packetizer (master) and the buffered UART transmitter (slave).
interface uart_tx_buffered_if #(
  parameter int unsigned PACKET_SIZE = 8
) ();
  logic                   send_flag;
  logic [PACKET_SIZE-1:0] send_data;
  logic                   sendable;

  modport master (output send_flag, output send_data, input sendable);
  modport slave  (input send_flag, input send_data, output sendable);
endinterface

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: start bit, PACKET_SIZE data bits LSB first, STOP_BITS stop bits.
// Frames are sent back to back while words remain queued.
module uart_tx_buffered #(
  parameter int unsigned PACKET_SIZE    = 8,
  parameter int unsigned BAUD_DIV       = 868,
  parameter int unsigned FIFO_DEPTH_BIT = 4,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_buffered_if.slave     send_if,
  output logic                  tx,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_BIT;
  localparam int unsigned CntW  = FIFO_DEPTH_BIT + 1;
  localparam int unsigned BaudW = $clog2(BAUD_DIV);
  localparam int unsigned BitW  = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;

  localparam logic [BaudW-1:0] BaudLast    = BaudW'(BAUD_DIV - 1);
  localparam logic [BitW-1:0]  BitLast     = BitW'(PACKET_SIZE - 1);
  localparam logic             StopLast    = 1'(STOP_BITS - 1);
  localparam logic [CntW-1:0]  DepthC      = CntW'(Depth);
  localparam logic [CntW-1:0]  SendableMax = CntW'(Depth - 2);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                      state_q, state_d;
  logic [PACKET_SIZE-1:0]      mem [Depth];
  logic [FIFO_DEPTH_BIT-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  logic                        overflow_q, overflow_d;
  logic                        tx_q, tx_d;
  logic [PACKET_SIZE-1:0]      sh_q, sh_d, sh_shift;
  logic [BaudW-1:0]            baud_q, baud_d;
  logic [BitW-1:0]             bit_q, bit_d;
  logic                        stop_q, stop_d;
  logic                        push, pop, baud_end, fifo_nonempty;

  assign baud_end      = (baud_q == BaudLast);
  assign fifo_nonempty = (count_q != '0);
  assign sh_shift      = sh_q >> 1;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
      sh_q       <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are valid.
  always_ff @(posedge CLK) begin
    if (RST && push) begin
      mem[wr_ptr_q] <= send_if.send_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fifo_nonempty) state_d = StStart;
      StStart: if (baud_end) state_d = StData;
      StData:  if (baud_end && bit_q == BitLast) state_d = StStop;
      StStop: begin
        if (baud_end && stop_q == StopLast) state_d = fifo_nonempty ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    tx_d   = tx_q;
    sh_d   = sh_q;
    baud_d = baud_q + 1'b1;
    bit_d  = bit_q;
    stop_d = stop_q;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (fifo_nonempty) begin
          pop  = 1'b1;
          sh_d = mem[rd_ptr_q];
          tx_d = 1'b0;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d = '0;
          tx_d   = sh_q[0];
          bit_d  = '0;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BitLast) begin
            tx_d   = 1'b1;
            stop_d = 1'b0;
          end else begin
            sh_d  = sh_shift;
            tx_d  = sh_shift[0];
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (stop_q == StopLast) begin
            // Chain straight into the next start bit so frames have no idle gap.
            if (fifo_nonempty) begin
              pop  = 1'b1;
              sh_d = mem[rd_ptr_q];
              tx_d = 1'b0;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d   = 1'b1;
        baud_d = '0;
      end
    endcase
  end

  // A pop frees a slot on the same edge, so a full FIFO still accepts a word then.
  always_comb begin
    push       = send_if.send_flag && ((count_q < DepthC) || pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | (send_if.send_flag & ~push);
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  assign tx               = tx_q;
  assign busy             = (state_q != StIdle) || fifo_nonempty;
  assign overflow         = overflow_q;
  assign send_if.sendable = (count_q <= SendableMax);

endmodule
